// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interface blocks: acknowledge-sequencer
// state encoding, default pulse timing and counter helpers.
package pic_pkg;

  // Acknowledge sequence: two NINTA pulses separated by a gap, then a
  // wait for the consumer to take the captured vector.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1_LOW = 3'd1,
    ST_GAP    = 3'd2,
    ST_P2_LOW = 3'd3,
    ST_DONE   = 3'd4
  } inta_state_t;

  // Default pulse timing in CLK cycles (legal range 1..15).
  localparam int unsigned INTA_LOW_CYC_DEF = 3;
  localparam int unsigned INTA_GAP_CYC_DEF = 2;

  // Width of the shared phase down-counter and of the vector byte.
  localparam int CNT_W = 4;
  localparam int VEC_W = 8;

  // Counter preload for a phase lasting 'cycles' clocks; the phase ends
  // on the clock where the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input. Generic so
// it can also be placed on the individual IR request lines.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; only q is used downstream.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its source; with = the chain would collapse into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: on a synchronized interrupt request with
// interrupts enabled, issues two NINTA pulses under LOCK, captures the
// vector byte the PIC drives during the second pulse, and holds it until
// the consumer acknowledges it.
//
// Pulse outputs are decoded from the state one clock late and come straight
// off flops, so NINTA/LOCK cannot glitch. The vector capture and VEC_VALID
// use the same one-clock offset, so observed at the pins a sequence looks
// like: state leaves IDLE (BUSY rises), next edge NINTA falls, and VEC_VALID
// rises on the edge that ends the second NINTA pulse.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYC = INTA_LOW_CYC_DEF,
  parameter int unsigned INTA_GAP_CYC = INTA_GAP_CYC_DEF
) (
  input  logic             CLK,
  input  logic             NRESET,
  input  logic             INT,
  input  logic             IF_EN,
  input  logic [VEC_W-1:0] D_IN,
  input  logic             VEC_ACK,
  output logic             NINTA,
  output logic             LOCK,
  output logic [VEC_W-1:0] VEC,
  output logic             VEC_VALID,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] LOW_LOAD = cnt_load(INTA_LOW_CYC);
  localparam logic [CNT_W-1:0] GAP_LOAD = cnt_load(INTA_GAP_CYC);

  inta_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             int_s;
  logic             ack_take;

  sync2 u_int_sync (
    .clk   (CLK),
    .rst_n (NRESET),
    .d     (INT),
    .q     (int_s)
  );

  // The consumer can only retire a vector that is actually presented.
  assign ack_take = (state == ST_DONE) && VEC_VALID && VEC_ACK;
  assign BUSY     = (state != ST_IDLE);

  // Next-state and shared phase-counter logic.
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (int_s && IF_EN) begin
          state_nxt = ST_P1_LOW;
          cnt_nxt   = LOW_LOAD;
        end
      end
      ST_P1_LOW: begin
        if (cnt == '0) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_P2_LOW;
          cnt_nxt   = LOW_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_P2_LOW: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (ack_take) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  // NOTE: all control state is cleared by the asynchronous reset; there is
  // no storage array here that could be left unreset.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered pulse outputs, decoded from the current state.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      NINTA <= 1'b1;
      LOCK  <= 1'b0;
    end else begin
      NINTA <= !((state == ST_P1_LOW) || (state == ST_P2_LOW));
      LOCK  <= (state == ST_P1_LOW) || (state == ST_GAP) || (state == ST_P2_LOW);
    end
  end

  // Vector capture on the edge that ends the second NINTA pulse; VEC holds
  // until the next capture, VEC_VALID drops on the accepting edge.
  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      VEC       <= '0;
      VEC_VALID <= 1'b0;
    end else if ((state == ST_DONE) && !VEC_VALID) begin
      VEC       <= D_IN;
      VEC_VALID <= 1'b1;
    end else if (ack_take) begin
      VEC_VALID <= 1'b0;
    end
  end

endmodule
